microwave_timer: RTL and testbench
==================================

Name: microwave_timer

Overview:
- Cook-time sequencer for the microwave oven FSM: holds the programmed cook time in seconds.
- Issues a one-cycle start request when the user presses start and the time is non-zero.
- Counts down only while the oven reports heating, and pulses finish when the count reaches zero.
- Duty-cycles the magnetron enable from the oven's heat output to implement four power levels.
- Sits between the keypad decoder and the oven FSM's start/finish/heat signals.

Parameters:
- TICK_DIV, 1000: clock cycles per one-second tick; legal range ≥ 2.
- TW, 10: width of the seconds counter.
- MAX_SECS, 999: saturation limit for load and add operations; MAX_SECS < 2**TW.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- load  in  1  pulse: remaining <= min(load_secs, MAX_SECS).
- load_secs  in  TW  time value for load.
- add30  in  1  pulse: remaining <= min(remaining+30, MAX_SECS).
- clear  in  1  pulse: cancel; remaining <= 0.
- start_key  in  1  pulse: user start request.
- power  in  2  power level 0..3, sampled every tick window.
- heat  in  1  oven FSM heat output (high in COOK).
- start  out  1  one-cycle start request to the oven FSM.
- finish  out  1  one-cycle finish pulse to the oven FSM.
- magnetron  out  1  gated heater drive.
- remaining  out  TW  seconds left, for the display.
- busy  out  1  high in RUNNING or PAUSED.

Behaviour:
- Reset (async, rst=1): state=IDLE, remaining=0, prescaler=0, window=0, and start/finish/magnetron/busy=0.
- Ports are named clk and rst; reset is asynchronous and active-high; single clock domain.
- Input priority within a cycle: clear > load > add30 > start_key.
- States:
  - IDLE (remaining=0).
    - load/add30 with a non-zero result -> ARMED.
    - start_key is ignored.
  - ARMED (remaining>0, not heating).
    - load/add30 update remaining.
    - clear -> IDLE.
    - start_key -> start=1 for one cycle and go to WAIT.
  - WAIT.
    - heat=1 -> RUNNING; prescaler=0, window=0.
    - No heat within 2 cycles (door open) -> ARMED.
    - clear -> IDLE.
  - RUNNING.
    - The prescaler increments every cycle; at TICK_DIV-1 it wraps to 0 and issues a tick.
    - On each tick, remaining decrements and window increments mod 4.
    - When remaining is 1 and a tick occurs: remaining=0, finish=1 for one cycle, state -> DONE.
    - heat falling (door opened) -> PAUSED; the prescaler value is frozen, not cleared.
    - add30 is allowed and saturates at MAX_SECS.
    - load is ignored.
    - clear -> remaining=0, finish pulse, state -> DONE. The oven then leaves COOK.
  - PAUSED.
    - heat=1 -> RUNNING, resuming from the frozen prescaler value.
    - clear -> IDLE with remaining=0.
    - load/add30 are ignored.
  - DONE.
    - Wait for heat=0, then -> IDLE.
- Magnetron duty: magnetron = heat & (state==RUNNING) & (window <= power).
  - power=3 gives continuous drive.
  - power=0 gives 1 tick in 4.
- remaining never underflows below 0 and never exceeds MAX_SECS.
- start and finish are never high in the same cycle.
- start pulses only when remaining > 0.
- Latency: start follows start_key by 1 cycle; finish coincides with the tick cycle + 1 (registered output).

Optional Feature:
- Macro MWT_QUICKSTART_EN.
  - Defined: add30 in IDLE loads 30 and, in the same action, asserts start one cycle later (-> WAIT).
  - Undefined: add30 in IDLE only loads 30 and moves to ARMED.

Decomposition:
- Package mw_timer_pkg:
  - typedef enum logic [2:0] mwt_state_t {IDLE, ARMED, WAIT, RUNNING, PAUSED, DONE}.
  - Constant ADD_SECS=30.
  - Constant WAIT_CYCLES=2.
- Sub-module mwt_tick_gen: the TICK_DIV prescaler, with inputs run, clear; outputs tick and frozen count.

Test Plan (TICK_DIV=4):
- Reset mid-RUNNING with remaining=7 -> next cycle state=IDLE, remaining=0, magnetron=0, busy=0.
- load_secs=3, start_key, heat raised 1 cycle after start -> remaining 3→2→1→0 at 4-cycle ticks; finish exactly one pulse; DONE; heat=0 -> IDLE.
- RUNNING with remaining=5, heat dropped for 10 cycles, then restored -> remaining stays 5 while paused; the countdown resumes with prescaler phase preserved; total heat cycles = 20.
- load_secs=990, then add30 -> remaining=999 (saturated); load_secs=1000 -> 999.
- power=1 with remaining=8 -> magnetron high for 2 ticks of every 4-tick window (8 of 16 cycles per window).
- start_key in IDLE -> no start pulse.
- clear and load in the same cycle -> remaining=0, IDLE.
- MWT_QUICKSTART_EN: add30 in IDLE -> remaining=30, start pulse on the next cycle.

Source files
------------

// File: rtl/mw_timer_pkg.sv
// mw_timer_pkg
// Shared types and constants for the microwave cook-time sequencer.
//   mwt_state_t : sequencer state encoding
//   ADD_SECS    : seconds added by one add30 press
//   WAIT_CYCLES : cycles the sequencer waits for the oven to raise heat
//                 after issuing start before falling back to ARMED
package mw_timer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        WAIT    = 3'd2,
        RUNNING = 3'd3,
        PAUSED  = 3'd4,
        DONE    = 3'd5
    } mwt_state_t;

    localparam int ADD_SECS    = 30;
    localparam int WAIT_CYCLES = 2;

endpackage

// File: rtl/mwt_tick_gen.sv
// mwt_tick_gen
// One-second prescaler. Counts clock cycles while run is high and emits a
// single-cycle tick on the cycle the count sits at TICK_DIV-1 (the count
// wraps to 0 on the following edge). When run is low the count is held,
// so a paused cook resumes with its sub-second phase intact.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   run      : advance the prescaler this cycle
//   clear    : synchronous restart of the prescaler at 0 (wins over run)
//   tick     : one-cycle pulse at the end of each second
//   count    : current (frozen when run is low) prescaler value
module mwt_tick_gen #(
    parameter int TICK_DIV = 1000,
    parameter int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          clear,
    output logic          tick,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (run) begin
            if (r_count == TC) r_count <= '0;
            else               r_count <= r_count + CW'(1);
        end
    end

    assign tick  = run && (r_count == TC);
    assign count = r_count;

endmodule

// File: rtl/microwave_timer.sv
// microwave_timer
// Cook-time sequencer between the keypad decoder and the oven FSM.
// Holds the programmed time in seconds, requests start from the oven,
// counts down while the oven heats, pulses finish at zero and duty-cycles
// the magnetron from the oven's heat output for four power levels.
// Optional build macro MWT_QUICKSTART_EN: add30 pressed in IDLE loads
// 30 s and immediately issues start (goes to WAIT instead of ARMED).
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   load/load_secs : set remaining to min(load_secs, MAX_SECS)
//   add30          : remaining += 30, saturating at MAX_SECS
//   clear          : cancel
//   start_key      : user start request
//   power          : power level 0..3 (3 = continuous)
//   heat           : oven FSM heat output
//   start, finish  : one-cycle requests to the oven FSM
//   magnetron      : gated heater drive
//   remaining      : seconds left, for the display
//   busy           : high while RUNNING or PAUSED
//
// state   | meaning
// IDLE    | no time programmed, remaining = 0
// ARMED   | time programmed, waiting for start_key
// WAIT    | start issued, waiting for oven heat
// RUNNING | oven heating, counting down
// PAUSED  | heat dropped (door open), prescaler frozen
// DONE    | countdown over, waiting for heat to drop
module microwave_timer
    import mw_timer_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int TW       = 10,
    parameter int MAX_SECS = 999
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] load_secs,
    input  logic          add30,
    input  logic          clear,
    input  logic          start_key,
    input  logic [1:0]    power,
    input  logic          heat,
    output logic          start,
    output logic          finish,
    output logic          magnetron,
    output logic [TW-1:0] remaining,
    output logic          busy
);

    localparam int            PCW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] MAX_V = TW'(MAX_SECS);
    localparam logic [TW:0]   ADD_V = (TW+1)'(ADD_SECS);
    localparam logic [1:0]    WAIT_LAST = 2'(WAIT_CYCLES - 1);

    mwt_state_t    r_state;
    logic [TW-1:0] r_rem;
    logic [1:0]    r_window;
    logic [1:0]    r_wait_cnt;
    logic          r_start;
    logic          r_finish;
    logic          r_mag;
    logic          r_busy;

    logic           w_run;
    logic           w_presc_clr;
    logic           w_tick;
    logic [PCW-1:0] w_presc_unused;
    logic [TW-1:0]  w_load_sat;
    logic [TW:0]    w_add_sum;
    logic [TW-1:0]  w_add_sat;

    assign w_run       = (r_state == RUNNING) && heat;
    // Held at zero while waiting for heat so every cook starts on a whole second.
    assign w_presc_clr = (r_state == WAIT);

    mwt_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .CW       (PCW)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .run   (w_run),
        .clear (w_presc_clr),
        .tick  (w_tick),
        .count (w_presc_unused)
    );

    assign w_load_sat = (load_secs > MAX_V) ? MAX_V : load_secs;
    assign w_add_sum  = {1'b0, r_rem} + ADD_V;
    assign w_add_sat  = (w_add_sum > {1'b0, MAX_V}) ? MAX_V : w_add_sum[TW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rem      <= '0;
            r_window   <= '0;
            r_wait_cnt <= '0;
            r_start    <= 1'b0;
            r_finish   <= 1'b0;
            r_mag      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_start  <= 1'b0;
            r_finish <= 1'b0;
            r_mag    <= heat && (r_state == RUNNING) && (r_window <= power);

            case (r_state)
                IDLE: begin
                    if (!clear) begin
                        if (load) begin
                            r_rem <= w_load_sat;
                            if (w_load_sat != '0) r_state <= ARMED;
                        end else if (add30 && (w_add_sat != '0)) begin
                            r_rem <= w_add_sat;
`ifdef MWT_QUICKSTART_EN
                            r_start    <= 1'b1;
                            r_wait_cnt <= '0;
                            r_state    <= WAIT;
`else
                            r_state    <= ARMED;
`endif
                        end
                    end
                end

                ARMED: begin
                    if (clear) begin
                        r_rem   <= '0;
                        r_state <= IDLE;
                    end else if (load) begin
                        r_rem <= w_load_sat;
                        if (w_load_sat == '0) r_state <= IDLE;
                    end else if (add30) begin
                        r_rem <= w_add_sat;
                    end else if (start_key) begin
                        r_start    <= 1'b1;
                        r_wait_cnt <= '0;
                        r_state    <= WAIT;
                    end
                end

                WAIT: begin
                    if (clear) begin
                        r_rem   <= '0;
                        r_state <= IDLE;
                    end else if (heat) begin
                        r_window <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= RUNNING;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_state <= ARMED;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 2'd1;
                    end
                end

                RUNNING: begin
                    if (clear) begin
                        r_rem    <= '0;
                        r_finish <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= DONE;
                    end else if (w_tick) begin
                        r_window <= r_window + 2'd1;
                        // An add30 landing on a tick still consumes that second.
                        if (add30) begin
                            r_rem <= w_add_sat - TW'(1);
                        end else if (r_rem <= TW'(1)) begin
                            r_rem    <= '0;
                            r_finish <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= DONE;
                        end else begin
                            r_rem <= r_rem - TW'(1);
                        end
                    end else begin
                        if (add30) r_rem <= w_add_sat;
                        if (!heat) r_state <= PAUSED;
                    end
                end

                PAUSED: begin
                    if (clear) begin
                        r_rem   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (heat) begin
                        r_state <= RUNNING;
                    end
                end

                DONE: begin
                    if (!heat) r_state <= IDLE;
                end

                default: begin
                    r_rem   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign start     = r_start;
    assign finish    = r_finish;
    assign magnetron = r_mag;
    assign remaining = r_rem;
    assign busy      = r_busy;

endmodule

// File: tb/tb_microwave_timer.sv
// tb_microwave_timer
// Directed bench for microwave_timer with TICK_DIV=4. Inputs change on the
// falling edge, outputs are sampled on the falling edge after each rising edge.
module tb_microwave_timer;

    localparam int TW = 10;

    logic          clk;
    logic          rst;
    logic          load;
    logic [TW-1:0] load_secs;
    logic          add30;
    logic          clear;
    logic          start_key;
    logic [1:0]    power;
    logic          heat;
    logic          start;
    logic          finish;
    logic          magnetron;
    logic [TW-1:0] remaining;
    logic          busy;

    int n_tests  = 0;
    int n_fail   = 0;
    int mag_cnt  = 0;
    int fin_cnt  = 0;
    int both_cnt = 0;

    microwave_timer #(
        .TICK_DIV (4),
        .TW       (TW),
        .MAX_SECS (999)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_secs (load_secs),
        .add30     (add30),
        .clear     (clear),
        .start_key (start_key),
        .power     (power),
        .heat      (heat),
        .start     (start),
        .finish    (finish),
        .magnetron (magnetron),
        .remaining (remaining),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        if (magnetron === 1'b1) mag_cnt++;
        if (finish === 1'b1) fin_cnt++;
        if (start === 1'b1 && finish === 1'b1) both_cnt++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; load_secs = '0; add30 = 1'b0; clear = 1'b0;
        start_key = 1'b0; power = 2'd0; heat = 1'b0;
        cyc(); cyc();
        check("rst_remaining", 32'(remaining), 0);
        check("rst_start", 32'(start), 0);
        check("rst_finish", 32'(finish), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_magnetron", 32'(magnetron), 0);
        rst = 1'b0;
        cyc();

        // Basic 3-second cook
        load = 1'b1; load_secs = 10'd3; cyc(); load = 1'b0;
        check("a_load", 32'(remaining), 3);
        check("a_busy_armed", 32'(busy), 0);
        start_key = 1'b1; cyc(); start_key = 1'b0;
        check("a_start", 32'(start), 1);
        cyc();
        check("a_start_once", 32'(start), 0);
        fin_cnt = 0;
        heat = 1'b1; cyc();                       // c0
        check("a_busy_run", 32'(busy), 1);
        check("a_rem_c0", 32'(remaining), 3);
        repeat (3) cyc();                         // c3
        check("a_rem_c3", 32'(remaining), 3);
        cyc();                                    // c4
        check("a_rem_c4", 32'(remaining), 2);
        repeat (4) cyc();                         // c8
        check("a_rem_c8", 32'(remaining), 1);
        repeat (3) cyc();                         // c11
        check("a_fin_c11", 32'(finish), 0);
        cyc();                                    // c12
        check("a_rem_c12", 32'(remaining), 0);
        check("a_fin_c12", 32'(finish), 1);
        check("a_busy_done", 32'(busy), 0);
        cyc();                                    // c13
        check("a_fin_c13", 32'(finish), 0);
        check("a_fin_count", 32'(fin_cnt), 1);
        heat = 1'b0; cyc();

        // start_key in IDLE is ignored; load works from IDLE
        start_key = 1'b1; cyc(); start_key = 1'b0;
        check("idle_start_key", 32'(start), 0);
        load = 1'b1; load_secs = 10'd2; cyc(); load = 1'b0;
        check("idle_load", 32'(remaining), 2);

        // clear beats load in the same cycle
        clear = 1'b1; load = 1'b1; load_secs = 10'd9; cyc();
        clear = 1'b0; load = 1'b0;
        check("clr_load_rem", 32'(remaining), 0);
        start_key = 1'b1; cyc(); start_key = 1'b0;
        check("clr_load_idle", 32'(start), 0);

        // Pause with prescaler phase preserved
        load = 1'b1; load_secs = 10'd5; cyc(); load = 1'b0;
        start_key = 1'b1; cyc(); start_key = 1'b0;
        cyc();
        power = 2'd3; mag_cnt = 0; fin_cnt = 0;
        heat = 1'b1; cyc();                       // c0
        cyc();                                    // c1
        heat = 1'b0; repeat (10) cyc();           // c11
        check("p_rem_paused", 32'(remaining), 5);
        check("p_busy_paused", 32'(busy), 1);
        check("p_mag_paused", 32'(magnetron), 0);
        heat = 1'b1; cyc();                       // c12
        cyc(); cyc();                             // c14
        check("p_rem_c14", 32'(remaining), 5);
        cyc();                                    // c15
        check("p_rem_c15_phase", 32'(remaining), 4);
        repeat (15) cyc();                        // c30
        check("p_rem_c30", 32'(remaining), 1);
        check("p_fin_c30", 32'(finish), 0);
        cyc();                                    // c31
        check("p_fin_c31", 32'(finish), 1);
        check("p_rem_c31", 32'(remaining), 0);
        check("p_heat_cycles", 32'(mag_cnt), 20);
        check("p_fin_count", 32'(fin_cnt), 1);
        heat = 1'b0; cyc();

        // Saturation
        load = 1'b1; load_secs = 10'd990; cyc(); load = 1'b0;
        check("s_load990", 32'(remaining), 990);
        add30 = 1'b1; cyc();
        check("s_add_sat", 32'(remaining), 999);
        cyc(); add30 = 1'b0;
        check("s_add_sat2", 32'(remaining), 999);
        load = 1'b1; load_secs = 10'd1000; cyc(); load = 1'b0;
        check("s_load1000", 32'(remaining), 999);
        load = 1'b1; load_secs = 10'd0; cyc(); load = 1'b0;
        check("s_load0", 32'(remaining), 0);
        start_key = 1'b1; cyc(); start_key = 1'b0;
        check("s_load0_idle", 32'(start), 0);

        // Power level 1 duty
        load = 1'b1; load_secs = 10'd8; cyc(); load = 1'b0;
        start_key = 1'b1; cyc(); start_key = 1'b0;
        cyc();
        power = 2'd1;
        heat = 1'b1; cyc();                       // c0
        mag_cnt = 0; fin_cnt = 0;
        repeat (16) cyc();                        // c16
        check("d_mag_win1", 32'(mag_cnt), 8);
        repeat (15) cyc();                        // c31
        check("d_fin_c31", 32'(finish), 0);
        cyc();                                    // c32
        check("d_fin_c32", 32'(finish), 1);
        check("d_mag_win2", 32'(mag_cnt), 16);
        heat = 1'b0; cyc();

        // clear while RUNNING finishes the cook
        load = 1'b1; load_secs = 10'd4; cyc(); load = 1'b0;
        start_key = 1'b1; cyc(); start_key = 1'b0;
        cyc();
        heat = 1'b1; cyc(); cyc();
        clear = 1'b1; cyc(); clear = 1'b0;
        check("c_fin", 32'(finish), 1);
        check("c_rem", 32'(remaining), 0);
        check("c_busy", 32'(busy), 0);
        cyc();
        check("c_fin_once", 32'(finish), 0);
        heat = 1'b0; cyc();
        check("c_mag_off", 32'(magnetron), 0);

        // No heat after start: fall back to ARMED
        load = 1'b1; load_secs = 10'd6; cyc(); load = 1'b0;
        start_key = 1'b1; cyc(); start_key = 1'b0;
        cyc(); cyc();
        start_key = 1'b1; cyc(); start_key = 1'b0;
        check("w_restart", 32'(start), 1);
        check("w_rem", 32'(remaining), 6);
        clear = 1'b1; cyc(); clear = 1'b0;
        check("w_clear_rem", 32'(remaining), 0);

        // Async reset mid-RUNNING
        load = 1'b1; load_secs = 10'd7; cyc(); load = 1'b0;
        start_key = 1'b1; cyc(); start_key = 1'b0;
        cyc();
        power = 2'd3; heat = 1'b1; cyc();         // c0
        repeat (5) cyc();                         // c5
        check("r_rem_pre", 32'(remaining), 6);
        check("r_mag_pre", 32'(magnetron), 1);
        rst = 1'b1; #1;
        check("r_rem_async", 32'(remaining), 0);
        check("r_busy_async", 32'(busy), 0);
        check("r_mag_async", 32'(magnetron), 0);
        cyc();
        rst = 1'b0; heat = 1'b0; cyc();

        // add30 from IDLE
        add30 = 1'b1; cyc(); add30 = 1'b0;
        check("q_rem", 32'(remaining), 30);
`ifdef MWT_QUICKSTART_EN
        check("q_start", 32'(start), 1);
`else
        check("q_start", 32'(start), 0);
`endif
        clear = 1'b1; cyc(); clear = 1'b0;
        check("q_clear", 32'(remaining), 0);

        check("start_finish_exclusive", 32'(both_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
